// File: rtl/memory_pkg.sv
// Shared types and default sizes for the word-addressed data memory.
package memory_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_DEPTH      = 256;

endpackage

// File: rtl/memory_if.sv
// Request/response bundle between a requester (pipeline or cache refill) and the data memory.
//
// Handshake: a request is read_enable or write_enable high at a rising edge while
// the memory is idle (write wins when both are high). busy_wait is high while a
// request is pending and not yet complete. The requester keeps its operands steady
// for the sampling edge only, and must drop its enables once busy_wait is low, or
// the next idle edge starts another access.
interface memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_enable;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy_wait;

  modport master (
    output address, data_in, read_enable, write_enable,
    input  data_out, busy_wait
  );

  modport slave (
    input  address, data_in, read_enable, write_enable,
    output data_out, busy_wait
  );
endinterface

// File: rtl/memory.sv
// Single-port word-addressed data memory with optional fixed stall latency.
// WAIT_CYCLES = 0 completes at the sampling edge; otherwise the access commits W edges later.
module memory
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = MEM_DEPTH,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  memory_if.slave    bus,
  output mem_state_t state_dbg
);

  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  mem_state_t             state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic                   req;
  logic                   start;
  logic                   commit;

  logic                   lat_we;
  logic [IDX_W-1:0]       lat_idx;
  logic [DATA_WIDTH-1:0]  lat_data;

  logic                   op_we;
  logic [IDX_W-1:0]       op_idx;
  logic [DATA_WIDTH-1:0]  op_data;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  data_out_q;
  logic                   unused_addr_bits;

  assign req              = bus.read_enable | bus.write_enable;
  assign unused_addr_bits = ^bus.address[ADDR_WIDTH-1:IDX_W];

  // Zero-wait accesses use the live inputs; stalled accesses use the operands latched at the request.
  assign op_we   = ZERO_WAIT ? bus.write_enable         : lat_we;
  assign op_idx  = ZERO_WAIT ? bus.address[IDX_W-1:0]   : lat_idx;
  assign op_data = ZERO_WAIT ? bus.data_in              : lat_data;

  assign bus.busy_wait = !ZERO_WAIT && ((state == BUSY) || req);
  assign bus.data_out  = data_out_q;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (ZERO_WAIT) begin
            commit = 1'b1;
          end else begin
            start      = 1'b1;
            state_next = BUSY;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
    end else if (start) begin
      lat_we   <= bus.write_enable;
      lat_idx  <= bus.address[IDX_W-1:0];
      lat_data <= bus.data_in;
    end
  end

  // Reset clears every word so reads of unwritten locations return 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && op_we) begin
      mem[op_idx] <= op_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else if (commit && !op_we) begin
      data_out_q <= mem[op_idx];
    end
  end

endmodule

// File: tb/tb_memory.sv
// Bench for the data memory: one zero-wait and one three-stall instance against an array model.
module tb_memory;
  import memory_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WC = 3;

  logic clk;
  logic reset;
  mem_state_t st0, st3;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] ref0 [256];
  logic [DW-1:0] ref3 [256];
  logic [DW-1:0] exp0;
  logic [DW-1:0] exp3;
  logic [DW-1:0] exp_q [$];

  memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_if ();
  memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m3_if ();

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_CYCLES(0)) u_m0 (
    .clk(clk), .reset(reset), .bus(m0_if.slave), .state_dbg(st0)
  );

  memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(256), .WAIT_CYCLES(WC)) u_m3 (
    .clk(clk), .reset(reset), .bus(m3_if.slave), .state_dbg(st3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      ref0[i] = '0;
      ref3[i] = '0;
    end
    exp0 = '0;
    exp3 = '0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    m0_if.address = '0; m0_if.data_in = '0; m0_if.read_enable = 1'b0; m0_if.write_enable = 1'b0;
    m3_if.address = '0; m3_if.data_in = '0; m3_if.read_enable = 1'b0; m3_if.write_enable = 1'b0;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_dout0"}, m0_if.data_out, exp0);
    check({tag, "_dout3"}, m3_if.data_out, exp3);
    check({tag, "_busy0"}, 32'(m0_if.busy_wait), 32'd0);
    check({tag, "_busy3"}, 32'(m3_if.busy_wait), 32'd0);
    check({tag, "_st3"}, 32'(st3), 32'(IDLE));
  endtask

  // Zero-wait access: completes at the next rising edge.
  task automatic op0(input bit we, input bit re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_if.address = a; m0_if.data_in = d;
    m0_if.write_enable = we; m0_if.read_enable = re;
    @(negedge clk);
    check("m0_busy", 32'(m0_if.busy_wait), 32'd0);
    @(posedge clk);
    #1;
    m0_if.read_enable = 1'b0; m0_if.write_enable = 1'b0;
    if (we) ref0[a % 256] = d;
    else if (re) exp_q.push_back(ref0[a % 256]);
    if (exp_q.size() != 0) exp0 = exp_q.pop_front();
    @(negedge clk);
    check("m0_dout", m0_if.data_out, exp0);
  endtask

  // Stalled access: busy from request, commits WC edges after the sampling edge.
  task automatic op3(input bit we, input bit re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int edges;
    bit done;
    m3_if.address = a; m3_if.data_in = d;
    m3_if.write_enable = we; m3_if.read_enable = re;
    #1;
    check("m3_busy_req", 32'(m3_if.busy_wait), 32'd1);
    @(posedge clk);
    #1;
    m3_if.read_enable = 1'b0; m3_if.write_enable = 1'b0;
    m3_if.address = $urandom; m3_if.data_in = $urandom;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 10) begin
      @(negedge clk);
      if (m3_if.busy_wait) begin
        check("m3_hold", m3_if.data_out, exp3);
        @(posedge clk);
        edges++;
      end else begin
        done = 1'b1;
      end
    end
    check("m3_latency", 32'(edges), 32'(WC));
    if (we) ref3[a % 256] = d;
    else if (re) exp_q.push_back(ref3[a % 256]);
    if (exp_q.size() != 0) exp3 = exp_q.pop_front();
    check("m3_dout", m3_if.data_out, exp3);
    check("m3_state", 32'(st3), 32'(IDLE));
  endtask

  initial begin
    bit we, re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    idle_inputs();
    clear_models();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check_idle_state("reset");

    op0(1'b0, 1'b1, 32'd10, '0);
    op3(1'b0, 1'b1, 32'd10, '0);

    op0(1'b1, 1'b0, 32'd10, 32'hABCDE123);
    op0(1'b1, 1'b0, 32'd10, 32'hABCDE123);
    op0(1'b0, 1'b1, 32'd10, '0);
    check("tp_read_new", m0_if.data_out, 32'hABCDE123);
    op0(1'b0, 1'b1, 32'd10, '0);

    // reset pulse wipes the array
    @(posedge clk); #2 reset = 1'b0;
    clear_models();
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check_idle_state("pulse");
    op0(1'b0, 1'b1, 32'd10, '0);
    check("tp_after_reset", m0_if.data_out, 32'h0);

    op0(1'b1, 1'b0, 32'd266, 32'h11111111);
    op0(1'b0, 1'b1, 32'd10, '0);
    check("tp_wrap", m0_if.data_out, 32'h11111111);
    op0(1'b1, 1'b1, 32'd10, 32'h22222222);
    check("tp_both_hold", m0_if.data_out, 32'h11111111);
    op0(1'b0, 1'b1, 32'd10, '0);
    check("tp_both_wrote", m0_if.data_out, 32'h22222222);

    op3(1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
    op3(1'b0, 1'b1, 32'd5, '0);
    check("tp_w3_read", m3_if.data_out, 32'hDEADBEEF);

    // reset lands mid-way through a pending stalled write
    m3_if.address = 32'd7; m3_if.data_in = 32'hCAFEF00D; m3_if.write_enable = 1'b1;
    @(posedge clk); #1;
    m3_if.write_enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_models();
    #1;
    check_idle_state("abort");
    #2 reset = 1'b1;
    @(negedge clk);
    op3(1'b0, 1'b1, 32'd7, '0);
    check("tp_abort_read", m3_if.data_out, 32'h0);

    // randomized traffic on both instances, addresses aliased across DEPTH
    for (int n = 0; n < 60; n++) begin
      we = ($urandom_range(0, 2) == 0);
      re = !we || ($urandom_range(0, 1) == 1);
      a  = 32'($urandom_range(0, 15) + 256 * $urandom_range(0, 7));
      d  = $urandom;
      if (n % 2 == 0) op0(we, re, a, d);
      else op3(we, re, a, d);
    end

    for (int i = 0; i < 16; i++) begin
      op0(1'b0, 1'b1, 32'(i), '0);
      op3(1'b0, 1'b1, 32'(i + 512), '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Parameterised, word-addressed, single-port data memory with a read/write request interface and a busy_wait handshake.
- Sits behind the pipeline data-memory stage or the cache refill path.
- Access latency is configurable: zero (single-cycle) or a fixed number of stall cycles.
- Asynchronous reset clears the whole array.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- ADDR_WIDTH, 32, width of the address port.
- DEPTH, 256, number of words; must be a power of two; index width IDX_W = log2(DEPTH).
- WAIT_CYCLES, 0, extra stall cycles per access (0 = access completes at the sampling edge).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- address  input  ADDR_WIDTH  word address; only address[IDX_W-1:0] is used.
- data_in  input  DATA_WIDTH  write data.
- read_enable  input  1  read request.
- write_enable  input  1  write request.
- data_out  output  DATA_WIDTH  registered read data; holds its value until the next completed read.
- busy_wait  output  1  high while a request is pending and not yet complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - All DEPTH words cleared to 0.
  - data_out = 0, busy_wait = 0, FSM = IDLE, wait counter = 0.
  - A pending access is aborted: an uncommitted write is discarded.
- Indexing: idx = address[IDX_W-1:0]. Upper bits are ignored, so addresses wrap modulo DEPTH.
- Request: read_enable or write_enable is high at a rising edge while the FSM is IDLE.
- Priority: write_enable has priority when both enables are high. The cycle is a write, and data_out is unchanged.
- Operands: address, data_in and the operation are latched when the request is sampled. Later input changes do not affect that access.
- WAIT_CYCLES = 0:
  - The access completes at the sampling edge N.
  - Write: mem[idx] <= data_in.
  - Read: data_out <= mem[idx], visible after edge N.
  - busy_wait stays 0.
  - Enables held high repeat the access every cycle; this is harmless and idempotent.
- WAIT_CYCLES = W > 0, FSM states IDLE and BUSY:
  - IDLE -> BUSY at the sampling edge; counter loads W.
  - BUSY: counter decrements each edge.
  - When the counter reaches 1, the access commits at that edge (write to array or load data_out) and the FSM returns to IDLE.
  - Completion therefore occurs at edge N+W.
  - busy_wait = BUSY, OR (IDLE and (read_enable or write_enable)), combinationally. It goes high in the same cycle the request is raised and falls right after the completing edge.
  - The requester must drop its enables once busy_wait is low. Enables still high at the next IDLE edge start a new access.
  - Enable changes while BUSY are ignored.
- data_out is never X after reset. Reading a never-written word returns 0.
- A read to the same index as a write completed at an earlier edge returns the new data.

Decomposition:
- Shared package memory_pkg holds:
  - state enum mem_state_t {IDLE, BUSY}
  - default width constants: DATA_WIDTH=32, DEPTH=256
- Single module; no sub-module needed. The array and the FSM together fit comfortably in one file.

Test Plan:
- Reset then read idx 10 -> data_out=0x00000000, busy_wait=0.
- WAIT_CYCLES=0: write 0xABCDE123 to address 10 for 2 cycles, then read address 10 for 2 cycles -> data_out=0xABCDE123 after the first read edge.
- Write 0xABCDE123 to address 10, pulse reset=0 for 1 cycle, read address 10 -> data_out=0x00000000.
- Wrap: with DEPTH=256, write 0x11111111 to address 266, read address 10 -> 0x11111111. Simultaneous read+write to address 10 with data 0x22222222 -> array updated, data_out unchanged.
- WAIT_CYCLES=3: write 0xDEADBEEF to address 5 at edge N -> busy_wait high from request until edge N+3; array updated at N+3. A read then returns 0xDEADBEEF three edges after sampling, and data_out is unchanged before that.
- WAIT_CYCLES=3: reset=0 asserted at edge N+1 of a pending write to address 7 -> busy_wait=0 immediately, FSM IDLE, read of address 7 returns 0.
